// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds the arbiter state encoding, grant encoding and default widths.
package mem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_WAIT = 2'd1,
        D_WAIT = 2'd2,
        I_DROP = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_perf_counters.sv
// Fetch-stall and data-request event counters for the memory port arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf_counters
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_stall,
    input  logic        data_accept,
    output logic [31:0] perf_fetch_stall_cnt,
    output logic [31:0] perf_data_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_stall_cnt <= '0;
            perf_data_cnt        <= '0;
        end else begin
            if (fetch_stall)
                perf_fetch_stall_cnt <= perf_fetch_stall_cnt + 32'd1;
            if (data_accept)
                perf_data_cnt <= perf_data_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and load/store requesters.
// Optional perf counters are enabled with MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [MASK_W-1:0] d_wmask,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_fetch_stall_cnt,
    output logic [31:0]       perf_data_cnt
`endif
);

    arb_state_t state;
    arb_state_t state_d;
    grant_t     grant;
    logic       free;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_d;
    end

    // A response in any wait state retires the transaction and frees
    // the slot in the same cycle, so the next request issues back-to-back.
    always_comb begin
        free  = (state == IDLE) || mem_resp_valid;
        grant = GNT_NONE;
        if (!rst && free) begin
            if (d_req_valid)
                grant = GNT_D;
            else if (i_req_valid && !flush)
                grant = GNT_I;
        end
    end

    always_comb begin
        mem_req_valid = (grant != GNT_NONE);
        mem_addr      = i_addr;
        mem_wdata     = '0;
        mem_wmask     = '0;
        if (grant == GNT_D) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_wmask = d_wmask;
        end
        d_req_ready = (grant == GNT_D) && mem_req_ready;
        i_req_ready = (grant == GNT_I) && mem_req_ready;
    end

    always_comb begin
        state_d = state;
        if (free) begin
            state_d = IDLE;
            if (mem_req_ready) begin
                case (grant)
                    GNT_D:   state_d = D_WAIT;
                    GNT_I:   state_d = I_WAIT;
                    default: state_d = IDLE;
                endcase
            end
        end else if (state == I_WAIT && flush) begin
            state_d = I_DROP;
        end
    end

    // A data access is older than any redirect, so flush never kills it.
    always_comb begin
        i_resp_valid = !rst && (state == I_WAIT) && mem_resp_valid && !flush;
        d_resp_valid = !rst && (state == D_WAIT) && mem_resp_valid;
        i_rdata      = mem_rdata;
        d_rdata      = mem_rdata;
    end

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf_counters u_perf (
        .clk                  (clk),
        .rst                  (rst),
        .fetch_stall          (i_req_valid && !i_req_ready && !flush),
        .data_accept          (d_req_valid && d_req_ready),
        .perf_fetch_stall_cnt (perf_fetch_stall_cnt),
        .perf_data_cnt        (perf_data_cnt)
    );
`endif

endmodule
